// File: rtl/bsg_fixed_latency_credit_buffer.sv
// Credit-gated issue into an external fixed-latency chain, with the chain output captured in an els_p-entry FIFO.
// Launch-to-v_o latency is latency_p+1; issue stalls when credits run out, so the downstream may hold yumi_i low indefinitely.
module bsg_fixed_latency_credit_buffer #(
    parameter int width_p   = 27,
    parameter int latency_p = 1,
    parameter int els_p     = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic               launch_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int cred_w = $clog2(els_p + 1);
    localparam int ptr_w  = (els_p > 1) ? $clog2(els_p) : 1;

    logic [cred_w-1:0]  credits;
    logic [cred_w-1:0]  count;
    logic [ptr_w-1:0]   rptr;
    logic [ptr_w-1:0]   wptr;
    logic [width_p-1:0] mem [els_p];
    logic               slot_v;
    logic [latency_p:0] trk_all;

    assign ready_o  = (credits != '0) & ~reset_i;
    assign launch_o = v_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits <= cred_w'(els_p);
        end else if (launch_o & ~yumi_i) begin
            credits <= credits - 1'b1;
        end else if (yumi_i & ~launch_o) begin
            credits <= credits + 1'b1;
        end
    end

    if (latency_p == 0) begin : g_pass
        assign slot_v  = launch_o;
        assign trk_all = '0;
    end else begin : g_trk
        // trk[i] is set when the chain's stage i holds a launched operation
        logic [latency_p:1] trk;
        logic [latency_p:1] trk_d;

        always_comb begin
            trk_d    = trk << 1;
            trk_d[1] = launch_o;
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                trk <= '0;
            end else begin
                trk <= trk_d;
            end
        end

        assign slot_v  = trk[latency_p];
        assign trk_all = {trk, 1'b0};
    end

    function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (slot_v) begin
                wptr <= ptr_next(wptr);
            end
            if (yumi_i) begin
                rptr <= ptr_next(rptr);
            end
            if (slot_v & ~yumi_i) begin
                count <= count + 1'b1;
            end else if (yumi_i & ~slot_v) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (slot_v) begin
            mem[wptr] <= data_i;
        end
    end

    assign v_o    = (count != '0);
    assign data_o = mem[rptr];

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("yumi_i asserted while fifo is empty");
            assert ((int'(credits) + int'(count) + $countones(trk_all)) == els_p)
                else $error("credit accounting broken: credits=%0d count=%0d inflight=%0d",
                            credits, count, $countones(trk_all));
        end
    end
`endif
endmodule

// File: tb/tb_bsg_fixed_latency_credit_buffer.sv
`timescale 1ns/1ps
module tb_bsg_fixed_latency_credit_buffer;
    localparam int W = 27;
    localparam int N = 4;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int els_of(input int k);
        case (k)
            0:       return 4;
            1:       return 4;
            2:       return 3;
            default: return 3;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         reset;
    logic         v_in    [N];
    logic         yumi    [N];
    logic         ready   [N];
    logic         launch  [N];
    logic         vout    [N];
    logic [W-1:0] operand [N];
    logic [W-1:0] chain   [N];
    logic [W-1:0] dout    [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = lat_of(g);
        logic [W-1:0] stg [4];

        // external fixed-latency chain, never stalled and never reset
        always @(posedge clk) begin
            stg[0] <= operand[g];
            for (int i = 1; i < 4; i++) stg[i] <= stg[i-1];
        end

        if (L == 0) begin : g_comb
            assign chain[g] = operand[g];
        end else begin : g_reg
            assign chain[g] = stg[L-1];
        end

        bsg_fixed_latency_credit_buffer #(
            .width_p  (W),
            .latency_p(L),
            .els_p    (els_of(g))
        ) dut (
            .clk_i   (clk),
            .reset_i (reset),
            .v_i     (v_in[g]),
            .ready_o (ready[g]),
            .launch_o(launch[g]),
            .data_i  (chain[g]),
            .v_o     (vout[g]),
            .data_o  (dout[g]),
            .yumi_i  (yumi[g])
        );
    end

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } ent_t;

    ent_t         sb      [N][$];
    int           cred    [N];
    logic [W-1:0] nextval [N];
    int           cyc;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // One cycle on instance k; all other instances are idle.
    task automatic step(input int k, input bit v, input bit y);
        bit   exp_v;
        bit   exp_launch;
        ent_t e;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        for (int j = 0; j < N; j++) begin
            v_in[j]    = 1'b0;
            yumi[j]    = 1'b0;
            operand[j] = W'($urandom);
        end
        exp_v      = (sb[k].size() > 0) && (sb[k][0].due <= cyc);
        exp_launch = v && (cred[k] != 0);
        v_in[k]    = v;
        yumi[k]    = y && exp_v;
        if (exp_launch) operand[k] = nextval[k];
        #1;
        chk($sformatf("k%0d_c%0d_ready", k, cyc), 32'(ready[k]), 32'(cred[k] != 0));
        chk($sformatf("k%0d_c%0d_launch", k, cyc), 32'(launch[k]), 32'(exp_launch));
        chk($sformatf("k%0d_c%0d_v_o", k, cyc), 32'(vout[k]), 32'(exp_v));
        if (exp_v) chk($sformatf("k%0d_c%0d_data_o", k, cyc), 32'(dout[k]), 32'(sb[k][0].d));
        if (exp_launch) begin
            e.d   = nextval[k];
            e.due = cyc + lat_of(k) + 1;
            sb[k].push_back(e);
            cred[k]--;
            nextval[k]++;
        end
        if (yumi[k]) begin
            void'(sb[k].pop_front());
            cred[k]++;
        end
    endtask

    // One reset cycle with every instance trying to issue.
    task automatic reset_step(input bit chk_vo);
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        for (int j = 0; j < N; j++) begin
            v_in[j]    = 1'b1;
            yumi[j]    = 1'b0;
            operand[j] = W'($urandom);
        end
        #1;
        for (int j = 0; j < N; j++) begin
            chk($sformatf("k%0d_rst_ready", j), 32'(ready[j]), 32'd0);
            chk($sformatf("k%0d_rst_launch", j), 32'(launch[j]), 32'd0);
            if (chk_vo) chk($sformatf("k%0d_rst_v_o", j), 32'(vout[j]), 32'd0);
            sb[j].delete();
            cred[j] = els_of(j);
        end
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (sb[k].size() > 0 && n < 30) begin
            step(k, 1'b0, 1'b1);
            n++;
        end
        step(k, 1'b0, 1'b0);
    endtask

    initial begin
        int nl;
        int i;
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        for (int j = 0; j < N; j++) begin
            v_in[j]    = 1'b0;
            yumi[j]    = 1'b0;
            operand[j] = '0;
            nextval[j] = W'(j * 1000 + 100);
        end
        reset_step(1'b0);
        reset_step(1'b1);

        // single launch through a one-stage chain, head held until consumed
        nextval[0] = 27'h1234567;
        repeat (3) step(0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);
        repeat (5) step(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1);
        drain(0);

        // full backpressure: only els_p launches get through
        nl = 0;
        repeat (8) begin
            step(3, 1'b1, 1'b0);
            if (launch[3]) nl++;
        end
        chk("backpressure_launches", 32'(nl), 32'd3);
        drain(3);

        // streaming at full throughput
        nl = 0;
        repeat (100) begin
            step(1, 1'b1, 1'b1);
            if (launch[1]) nl++;
        end
        chk("stream_launches", 32'(nl), 32'd100);
        drain(1);

        // pass-through chain, values 1..7 across pointer wrap
        nextval[2] = 27'd1;
        i = 0;
        while (nextval[2] <= 27'd7 && i < 40) begin
            step(2, 1'b1, (i % 2) == 1);
            i++;
        end
        chk("passthru_issued", 32'(nextval[2]), 32'd8);
        drain(2);

        // credit-blocked issue with pops landing alongside in-flight writes
        for (int s = 0; s < 16; s++) step(3, 1'b1, (s >= 4) && ((s % 3) != 1));
        drain(3);

        // reset with two ops buffered and two in flight; stale chain data must be ignored
        repeat (4) step(1, 1'b1, 1'b0);
        reset_step(1'b0);
        repeat (4) step(1, 1'b0, 1'b0);
        repeat (6) step(1, 1'b1, 1'b1);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
